// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing helpers for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

  // Bits needed to hold a count ranging over 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: redirect, memory request/response and decode handshake.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_addr, req_ready, resp_valid, resp_data, instr_ready,
    output req_valid, req_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_addr, req_ready, resp_valid, resp_data, instr_ready,
    input  req_valid, req_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with flush; head is read combinationally, push/pop take effect on the clock edge.
// Push while full is accepted only together with a pop; flush wins over push and pop.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        push_dat,
  input  logic                pop,
  input  logic                flush,
  output logic [W-1:0]        head_dat,
  output logic [cnt_w(D)-1:0] count
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so D need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop & (count != '0);
  assign do_push  = push & ((int'(count) < D) | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generator, credit-limited memory requests, DEPTH-entry queue toward decode.
// Response reaches decode one cycle later (same cycle into an empty queue with FETCH_QUEUE_BYPASS_EN); decode stalls via instr_ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int OW = cnt_w(MAX_OUTSTANDING);
  localparam int EW = XLEN + ILEN;

  logic [XLEN-1:0] pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   stale;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] resp_pc;
  logic [EW-1:0]   head;
  logic            credit_ok;
  logic            fire;
  logic            resp_keep;
  logic            byp;
  logic            q_nonempty;
  logic            q_push;
  logic            q_pop;

  // Every live request owns a queue slot, so a kept response can always be written.
  assign credit_ok = (int'(count) + int'(outstanding) - int'(stale)) < DEPTH;

  assign bus.req_valid = rst & ~bus.redirect_valid
                       & (int'(outstanding) < MAX_OUTSTANDING) & credit_ok;
  assign bus.req_addr  = pc;
  assign fire          = bus.req_valid & bus.req_ready;

  assign resp_keep  = bus.resp_valid & (stale == '0);
  assign q_nonempty = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = resp_keep & ~q_nonempty & ~bus.redirect_valid;
`else
  assign byp = 1'b0;
`endif

  assign q_push = resp_keep & ~(byp & bus.instr_ready);
  assign q_pop  = bus.instr_ready & q_nonempty;

  always_comb begin
    bus.instr_valid = q_nonempty | byp;
    bus.instr_data  = '0;
    bus.instr_pc    = '0;
    if (q_nonempty) begin
      bus.instr_pc   = head[EW-1:ILEN];
      bus.instr_data = head[ILEN-1:0];
    end else if (byp) begin
      bus.instr_pc   = resp_pc;
      bus.instr_data = bus.resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      stale <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      pc    <= bus.redirect_addr;
      stale <= outstanding - OW'(bus.resp_valid);
    end else begin
      if (fire) pc <= pc + XLEN'(4);
      if (bus.resp_valid && stale != '0) stale <= stale - OW'(1);
    end
  end

  // In-flight PC FIFO; its occupancy is the outstanding-request count.
  fetch_queue_fifo #(
    .W (XLEN),
    .D (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fire),
    .push_dat (pc),
    .pop      (bus.resp_valid),
    .flush    (1'b0),
    .head_dat (resp_pc),
    .count    (outstanding)
  );

  fetch_queue_fifo #(
    .W (EW),
    .D (DEPTH)
  ) u_instr_q (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_dat ({resp_pc, bus.resp_data}),
    .pop      (q_pop),
    .flush    (bus.redirect_valid),
    .head_dat (head),
    .count    (count)
  );

endmodule
